// File: rtl/dac_serial_pkg.sv
// Shared types and sizing helpers for the multi-channel DAC serialiser.
package dac_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_SYNC_GAP = 2;

    // Width of a counter that must reach the terminal value term.
    function automatic int unsigned cnt_width(input int unsigned term);
        return (term < 1) ? 1 : $clog2(term + 1);
    endfunction

    // Number of clk cycles SYNC is held low for one frame.
    function automatic int unsigned frame_cycles(input int unsigned width, input int unsigned clk_div);
        return width * 2 * clk_div;
    endfunction

    localparam int unsigned DEF_FRAME_CYCLES = frame_cycles(DEF_WIDTH, DEF_CLK_DIV);

endpackage

// File: rtl/dac_shift_reg.sv
// One channel's frame shift register; loads a word and shifts it out MSB first.
module dac_shift_reg
    import dac_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift_en) begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_sreg[WIDTH-1];

endmodule

// File: rtl/dac_serial_multi.sv
// Multi-channel DAC serialiser: shared SYNC/SCLK, one DIN per channel,
// programmable SCLK divider, SYNC-high gap and a one-deep pending request.
module dac_serial_multi
    import dac_serial_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SYNC_GAP = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic                    SYNC,
    output logic                    SCLK,
    output logic [NUM_CH-1:0]       DIN
);

    localparam int unsigned BIT_W  = cnt_width(WIDTH);
    localparam int unsigned DIV_W  = cnt_width(CLK_DIV);
    localparam int unsigned GAP_W  = cnt_width(SYNC_GAP);
    localparam int unsigned DATA_W = NUM_CH * WIDTH;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_phase_lo;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [DATA_W-1:0] r_hold;
    logic              r_pending;

    logic              r_sync;
    logic              r_sclk;
    logic [NUM_CH-1:0] r_din;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;

    logic              w_half_end;
    logic              w_bit_end;
    logic              w_last_bit;
    logic              w_gap_end;
    logic              w_load_hold;
    logic              w_load_data;
    logic              w_load;
    logic              w_busy_start;
    logic              w_shift_en;
    logic [DATA_W-1:0] w_load_word;
    logic [NUM_CH-1:0] w_msb;

    // Frame timing and request-arbitration decodes.
    always_comb begin
        w_half_end   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
        w_bit_end    = w_half_end && r_phase_lo;
        w_last_bit   = (r_bit_cnt == BIT_W'(WIDTH - 1));
        w_gap_end    = (r_gap_cnt == GAP_W'(SYNC_GAP - 1));
        w_load_hold  = r_pending && ((r_state == IDLE) || (r_state == DONE));
        w_load_data  = start && !r_pending && (r_state == IDLE);
        w_load       = w_load_hold || w_load_data;
        w_busy_start = start && !w_load_data;
        w_shift_en   = (r_state == SHIFT) && w_bit_end;
        w_load_word  = w_load_hold ? r_hold : data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_load) w_state_nxt = SHIFT;
            SHIFT:   if (w_bit_end && w_last_bit) w_state_nxt = GAP;
            GAP:     if (w_gap_end) w_state_nxt = DONE;
            DONE:    w_state_nxt = w_load ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Divider, bit and gap counters; all saturate at their terminal counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_phase_lo <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_bit_cnt  <= '0;
                r_div_cnt  <= '0;
                r_phase_lo <= 1'b0;
            end else if (r_state == SHIFT) begin
                if (w_half_end) begin
                    r_div_cnt  <= '0;
                    r_phase_lo <= ~r_phase_lo;
                    if (r_phase_lo && !w_last_bit) begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end
            if (r_state != GAP) begin
                r_gap_cnt <= '0;
            end else if (!w_gap_end) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
        end
    end

    // Pending buffer: latest busy start wins; overwriting a live request flags overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_busy_start && r_pending && !w_load_hold;
            if (w_busy_start) begin
                r_hold    <= data;
                r_pending <= 1'b1;
            end else if (w_load_hold) begin
                r_pending <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dac_shift_reg #(
            .WIDTH (WIDTH)
        ) u_sreg (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load),
            .i_shift_en (w_shift_en),
            .i_data     (w_load_word[c*WIDTH +: WIDTH]),
            .o_msb      (w_msb[c])
        );
    end

    // Pin drivers lag the state by one cycle so every output comes from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 1'b1;
            r_sclk <= 1'b1;
            r_din  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sync <= (r_state != SHIFT);
            r_sclk <= !((r_state == SHIFT) && r_phase_lo);
            r_din  <= (r_state == SHIFT) ? w_msb : '0;
            r_busy <= (r_state != IDLE);
            r_done <= (r_state == DONE);
        end
    end

    assign SYNC    = r_sync;
    assign SCLK    = r_sclk;
    assign DIN     = r_din;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_dac_serial_multi.sv
// Directed bench for dac_serial_multi: default instance plus a CLK_DIV=1 instance.
module tb_dac_serial_multi;

    localparam int NREC = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0, start1;
    logic [127:0] data0;
    logic [31:0]  data1;
    logic         busy0, done0, ovr0, sync0, sclk0;
    logic         busy1, done1, ovr1, sync1, sclk1;
    logic [7:0]   din_b0;
    logic [1:0]   din_b1;

    always #5 clk = ~clk;

    dac_serial_multi u_dut0 (
        .clk(clk), .rst(rst), .data(data0), .start(start0),
        .busy(busy0), .done(done0), .overrun(ovr0),
        .SYNC(sync0), .SCLK(sclk0), .DIN(din_b0)
    );

    dac_serial_multi #(.WIDTH(16), .NUM_CH(2), .CLK_DIV(1), .SYNC_GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .data(data1), .start(start1),
        .busy(busy1), .done(done1), .overrun(ovr1),
        .SYNC(sync1), .SCLK(sclk1), .DIN(din_b1)
    );

    logic sel;
    logic m_sync, m_sclk, m_din0, m_din1, m_busy, m_done, m_ovr;
    always_comb begin
        m_sync = sel ? sync1     : sync0;
        m_sclk = sel ? sclk1     : sclk0;
        m_din0 = sel ? din_b1[0] : din_b0[0];
        m_din1 = sel ? din_b1[1] : din_b0[1];
        m_busy = sel ? busy1     : busy0;
        m_done = sel ? done1     : done0;
        m_ovr  = sel ? ovr1      : ovr0;
    end

    int n_vec = 0;
    int n_err = 0;

    logic rec_sync[NREC], rec_sclk[NREC], rec_din0[NREC], rec_din1[NREC];
    logic rec_busy[NREC], rec_done[NREC], rec_ovr[NREC];

    int          n_inj;
    int          inj_rel[4];
    logic [15:0] inj_d0[4], inj_d1[4];

    typedef struct {
        logic        sel;
        logic [15:0] d0, d1;
        int          exp_low, exp_falls, exp_lat, exp_per;
        logic [15:0] exp_w0, exp_w1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input int r);
        logic        s;
        logic [15:0] d0, d1;
        s = 1'b0; d0 = '0; d1 = '0;
        for (int i = 0; i < n_inj; i++) begin
            if (inj_rel[i] == r) begin
                s = 1'b1; d0 = inj_d0[i]; d1 = inj_d1[i];
            end
        end
        start0 = s & ~sel;
        start1 = s & sel;
        data0  = {96'b0, d1, d0};
        data1  = {d1, d0};
    endtask

    // Record index r holds outputs in the cycle after edge T+r (T = rel 0 start).
    task automatic run_seq(input int ncyc);
        for (int r = 0; r < NREC; r++) begin
            rec_sync[r] = 1'b1; rec_sclk[r] = 1'b1; rec_din0[r] = 1'b0; rec_din1[r] = 1'b0;
            rec_busy[r] = 1'b0; rec_done[r] = 1'b0; rec_ovr[r] = 1'b0;
        end
        @(negedge clk);
        drive_start(0);
        for (int r = 0; r < ncyc; r++) begin
            @(negedge clk);
            rec_sync[r] = m_sync; rec_sclk[r] = m_sclk; rec_din0[r] = m_din0;
            rec_din1[r] = m_din1; rec_busy[r] = m_busy; rec_done[r] = m_done;
            rec_ovr[r]  = m_ovr;
            drive_start(r + 1);
        end
        start0 = 1'b0; start1 = 1'b0;
    endtask

    function automatic int nth_sync_fall(input int n);
        int k = 0;
        logic prev = 1'b1;
        for (int r = 0; r < NREC; r++) begin
            if (prev && !rec_sync[r]) begin
                k++;
                if (k == n) return r;
            end
            prev = rec_sync[r];
        end
        return -1;
    endfunction

    function automatic int sync_rise_after(input int from);
        if (from < 0) return -1;
        for (int r = from + 1; r < NREC; r++)
            if (!rec_sync[r-1] && rec_sync[r]) return r;
        return -1;
    endfunction

    function automatic int nth_sclk_fall(input int n);
        int k = 0;
        logic prev = 1'b1;
        for (int r = 0; r < NREC; r++) begin
            if (prev && !rec_sclk[r]) begin
                k++;
                if (k == n) return r;
            end
            prev = rec_sclk[r];
        end
        return -1;
    endfunction

    function automatic int count_sclk_falls();
        int k = 0;
        logic prev = 1'b1;
        for (int r = 0; r < NREC; r++) begin
            if (prev && !rec_sclk[r]) k++;
            prev = rec_sclk[r];
        end
        return k;
    endfunction

    function automatic int count_sync_low();
        int k = 0;
        for (int r = 0; r < NREC; r++) if (!rec_sync[r]) k++;
        return k;
    endfunction

    function automatic int first_done();
        for (int r = 0; r < NREC; r++) if (rec_done[r]) return r;
        return -1;
    endfunction

    function automatic int first_ovr();
        for (int r = 0; r < NREC; r++) if (rec_ovr[r]) return r;
        return -1;
    endfunction

    function automatic int count_ovr();
        int k = 0;
        for (int r = 0; r < NREC; r++) if (rec_ovr[r]) k++;
        return k;
    endfunction

    // Word seen by the DAC on one channel: DIN sampled at the 16 SCLK falls after a SYNC fall.
    function automatic logic [15:0] decode(input int from, input bit ch);
        logic [15:0] w = '0;
        int   got = 0;
        logic prev;
        if (from < 0) return 16'hDEAD;
        prev = rec_sclk[from];
        for (int r = from + 1; r < NREC && got < 16; r++) begin
            if (prev && !rec_sclk[r]) begin
                w = {w[14:0], ch ? rec_din1[r] : rec_din0[r]};
                got++;
            end
            prev = rec_sclk[r];
        end
        return w;
    endfunction

    vec_t vecs[6];

    initial begin
        int lat, f1, f2, rise, dcnt;

        vecs[0] = '{1'b0, 16'h8005, 16'hFFFF, 64, 16, 67, 4, 16'h8005, 16'hFFFF};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 64, 16, 67, 4, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 16'hA5A5, 16'h5A5A, 64, 16, 67, 4, 16'hA5A5, 16'h5A5A};
        vecs[3] = '{1'b0, 16'h0001, 16'h8000, 64, 16, 67, 4, 16'h0001, 16'h8000};
        vecs[4] = '{1'b1, 16'hA5A5, 16'h0000, 32, 16, 35, 2, 16'hA5A5, 16'h0000};
        vecs[5] = '{1'b1, 16'hC3E1, 16'h7F80, 32, 16, 35, 2, 16'hC3E1, 16'h7F80};

        sel = 1'b0; start0 = 1'b0; start1 = 1'b0; data0 = '0; data1 = '0; n_inj = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst SYNC", 32'(sync0), 32'd1);
        chk("rst SCLK", 32'(sclk0), 32'd1);
        chk("rst DIN", 32'(din_b0), 32'd0);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst done", 32'(done0), 32'd0);
        chk("rst overrun", 32'(ovr0), 32'd0);
        chk("rst SYNC div1", 32'(sync1), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            n_inj = 1; inj_rel[0] = 0; inj_d0[0] = vecs[i].d0; inj_d1[0] = vecs[i].d1;
            run_seq(80);
            lat = first_done();
            chk($sformatf("v%0d busy@T", i), 32'(rec_busy[0]), 32'd0);
            chk($sformatf("v%0d busy@T+1", i), 32'(rec_busy[1]), 32'd1);
            chk($sformatf("v%0d sync_fall", i), 32'(nth_sync_fall(1)), 32'd1);
            chk($sformatf("v%0d sync_low", i), 32'(count_sync_low()), 32'(vecs[i].exp_low));
            chk($sformatf("v%0d sclk_falls", i), 32'(count_sclk_falls()), 32'(vecs[i].exp_falls));
            chk($sformatf("v%0d sclk_period", i), 32'(nth_sclk_fall(2) - nth_sclk_fall(1)),
                32'(vecs[i].exp_per));
            chk($sformatf("v%0d done_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d busy_after", i), 32'(rec_busy[(lat < 0) ? 0 : lat + 1]), 32'd0);
            chk($sformatf("v%0d ch0", i), 32'(decode(1, 1'b0)), 32'(vecs[i].exp_w0));
            chk($sformatf("v%0d ch1", i), 32'(decode(1, 1'b1)), 32'(vecs[i].exp_w1));
            chk($sformatf("v%0d no_ovr", i), 32'(count_ovr()), 32'd0);
        end
        sel = 1'b0;

        // Back-to-back: second request pended, SYNC high for exactly 3 cycles between frames.
        n_inj = 2;
        inj_rel[0] = 0;  inj_d0[0] = 16'hAAAA; inj_d1[0] = 16'h0000;
        inj_rel[1] = 10; inj_d0[1] = 16'h1234; inj_d1[1] = 16'h0000;
        run_seq(150);
        f1 = nth_sync_fall(1); f2 = nth_sync_fall(2); rise = sync_rise_after(f1);
        chk("b2b no_ovr", 32'(count_ovr()), 32'd0);
        chk("b2b done1", 32'(first_done()), 32'd67);
        chk("b2b fall2", 32'(f2), 32'd68);
        chk("b2b sync_gap", 32'(f2 - rise), 32'd3);
        chk("b2b frame1", 32'(decode(f1, 1'b0)), 32'hAAAA);
        chk("b2b frame2", 32'(decode(f2, 1'b0)), 32'h1234);

        // Three starts: the third overwrites the pended second and flags overrun.
        n_inj = 3;
        inj_rel[0] = 0; inj_d0[0] = 16'h0F0F; inj_d1[0] = 16'h0000;
        inj_rel[1] = 5; inj_d0[1] = 16'h1111; inj_d1[1] = 16'h0000;
        inj_rel[2] = 6; inj_d0[2] = 16'h2222; inj_d1[2] = 16'h0000;
        run_seq(150);
        chk("ovr at", 32'(first_ovr()), 32'd6);
        chk("ovr width", 32'(count_ovr()), 32'd1);
        chk("ovr frame1", 32'(decode(nth_sync_fall(1), 1'b0)), 32'h0F0F);
        chk("ovr frame2", 32'(decode(nth_sync_fall(2), 1'b0)), 32'h2222);
        chk("ovr no_frame3", 32'(nth_sync_fall(3)), 32'hFFFF_FFFF);

        // Start during the DONE cycle with nothing pending.
        n_inj = 2;
        inj_rel[0] = 0;  inj_d0[0] = 16'h5555; inj_d1[0] = 16'h0000;
        inj_rel[1] = 67; inj_d0[1] = 16'h3C3C; inj_d1[1] = 16'h0000;
        run_seq(150);
        f2 = nth_sync_fall(2);
        chk("done_start no_ovr", 32'(count_ovr()), 32'd0);
        chk("done_start fall2", 32'((f2 == 68) || (f2 == 69)), 32'd1);
        chk("done_start frame2", 32'(decode(f2, 1'b0)), 32'h3C3C);

        // Asynchronous reset in the middle of a frame.
        @(negedge clk);
        start0 = 1'b1; data0 = {96'b0, 16'hFFFF, 16'h8005};
        @(negedge clk);
        start0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid pre SYNC", 32'(sync0), 32'd0);
        chk("mid pre SCLK", 32'(sclk0), 32'd0);
        chk("mid pre DIN1", 32'(din_b0[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid SYNC", 32'(sync0), 32'd1);
        chk("mid SCLK", 32'(sclk0), 32'd1);
        chk("mid DIN", 32'(din_b0), 32'd0);
        chk("mid busy", 32'(busy0), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done0) dcnt++;
        end
        rst = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done0) dcnt++;
        end
        chk("mid no_done", 32'(dcnt), 32'd0);

        n_inj = 1; inj_rel[0] = 0; inj_d0[0] = 16'h8005; inj_d1[0] = 16'hFFFF;
        run_seq(80);
        chk("post_rst sync_fall", 32'(nth_sync_fall(1)), 32'd1);
        chk("post_rst done_lat", 32'(first_done()), 32'd67);
        chk("post_rst ch0", 32'(decode(1, 1'b0)), 32'h8005);
        chk("post_rst ch1", 32'(decode(1, 1'b1)), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_serial_multi.md
Name: dac_serial_multi

Overview:
- Parametrised successor to the single-channel 16-bit DAC serialiser.
- Drives NUM_CH DAC chips in parallel: one shared SYNC and SCLK, with one DIN line per channel.
- Adds a programmable SCLK divider, a guaranteed SYNC-high gap between frames, and a one-deep pending-request buffer so back-to-back updates are never dropped.
- Sits between the DAC register AXI slave and the DAC board connector.

Parameters:
- WIDTH, 16, bits per DAC frame (legal 8..32), shifted MSB first.
- NUM_CH, 8, number of parallel DAC channels (legal 1..16).
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
- SYNC_GAP, 2, clk cycles SYNC held high after each frame before done/next frame (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data  in  NUM_CH*WIDTH  channel c word at bits [c*WIDTH +: WIDTH]; sampled on start
- start  in  1  single-cycle request; sampled on rising clk edge
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted (inclusive)
- done  out  1  one-cycle pulse at end of frame, including the SYNC_GAP
- overrun  out  1  one-cycle pulse when start arrives while a request is already pending
- SYNC  out  1  frame sync, active low
- SCLK  out  1  serial clock; idles high; DAC samples DIN on falling edge
- DIN  out  NUM_CH  serial data, one bit per channel

Behaviour:
- Reset (async, rst=1): SYNC=1, SCLK=1, DIN=0, busy=0, done=0, overrun=0. The pending buffer is cleared and the FSM goes to IDLE. Reset mid-frame aborts immediately; SYNC rises asynchronously.
- FSM states:
  - IDLE -> SHIFT on start. data is latched into the per-channel shift registers. The accepting edge is cycle T.
  - SHIFT -> GAP after WIDTH bit periods.
  - GAP -> DONE after SYNC_GAP cycles.
  - DONE -> SHIFT if pending, else IDLE.
- Signals per state:
  - IDLE: SYNC=1, SCLK=1, DIN=0, busy=0.
  - SHIFT: SYNC=0 from T+1. Each bit period is 2*CLK_DIV cycles: CLK_DIV cycles SCLK=1, then CLK_DIV cycles SCLK=0. DIN[c] holds bit (WIDTH-1-k) of channel c for all of bit period k, changing only at period start. The first high phase provides SYNC-to-SCLK setup.
  - GAP: SYNC=1, SCLK=1, DIN=0, for SYNC_GAP cycles.
  - DONE: a single cycle; done=1 and busy=1. SYNC stays 1.
- Latency: SYNC is low for exactly WIDTH*2*CLK_DIV cycles. done is high in cycle T+1+WIDTH*2*CLK_DIV+SYNC_GAP. Defaults: T+67.
- All outputs are registered. No glitches on SYNC or SCLK.
- Pending buffer:
  - start while state != IDLE: data is copied to the hold register and pending=1.
  - start while pending=1: hold is overwritten (latest wins) and overrun pulses for one cycle.
  - In DONE with pending=1: hold is loaded into the shift registers, pending clears, and SYNC falls in the next cycle. The SYNC-high gap is still exactly SYNC_GAP+1 cycles.
- Simultaneous events:
  - start in the DONE cycle counts as a busy start; it is pended or triggers overrun per the rules above.
  - start in IDLE is never pended.
- Counters: bit counter of width $clog2(WIDTH+1) and divider counter of width $clog2(CLK_DIV+1), with no wrap beyond terminal counts. The gap counter follows the same rule.

Decomposition:
- Package dac_serial_pkg holds:
  - state enum (IDLE, SHIFT, GAP, DONE);
  - localparam functions for counter widths;
  - frame-length constant WIDTH*2*CLK_DIV.
- Sub-module dac_shift_reg, instantiated NUM_CH times (generate loop), contains:
  - a WIDTH-bit shift register with load, shift-enable and MSB output;
  - no control logic.
- The top level owns the FSM, divider, counters, hold register and pending flag.

Test Plan:
- Reset, then a single start with defaults and ch0=16'h8005, ch1=16'hFFFF, others 0:
  - SYNC low for exactly 64 cycles;
  - 16 SCLK falling edges;
  - DIN[0] bits sampled at falling edges = 1000_0000_0000_0101, DIN[1] all ones;
  - done in cycle T+67, busy low the cycle after.
- CLK_DIV=1, WIDTH=16, SYNC_GAP=2, start with ch0=16'hA5A5: SYNC low 32 cycles, done at T+35, SCLK period 2 cycles.
- start at T and a second start (ch0=16'h1234) at T+10:
  - no overrun;
  - second frame's SYNC falls in cycle T+68, i.e. SYNC high for 3 cycles;
  - second frame carries 16'h1234.
- Three starts at T, T+5 (16'h1111) and T+6 (16'h2222): overrun pulses at T+6, and the second frame shifts 16'h2222.
- rst asserted mid-frame at T+20: SYNC=1, SCLK=1, DIN=0 immediately (before the next clk edge); busy=0; no done; next start behaves as from a fresh reset.
- start held high in the DONE cycle with pending=0: the frame is pended and starts immediately after, with no overrun.
